// File: rtl/cl_word_unpacker.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cl_word_unpacker                                                            |
// | Pops cache lines from the DMA read FIFO and streams them out as words       |
// | under valid/ready, counting lines and raising done after the final word.    |
// | Optional: CL_UNPACK_BYTE_SWAP_EN byte-reverses each output word.            |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module cl_word_unpacker #(
  parameter int CL_WIDTH   = 512,
  parameter int WORD_WIDTH = 32,
  parameter int SIZE_WIDTH = 43
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [SIZE_WIDTH-1:0] size,
  input  logic                  dma_empty,
  input  logic [CL_WIDTH-1:0]   dma_rd_data,
  output logic                  dma_rd_en,
  output logic                  word_valid,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_last,
  input  logic                  word_ready,
  output logic                  done
);

  localparam int c_WORDS = CL_WIDTH / WORD_WIDTH;
  localparam int c_IDX_W = $clog2(c_WORDS);
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [CL_WIDTH-1:0]   r_buf;
  logic                  r_buf_valid;
  logic [c_IDX_W-1:0]    r_idx;
  logic [SIZE_WIDTH-1:0] r_lines_left;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_at_last;
  logic                  w_rd_en;
  logic [WORD_WIDTH-1:0] w_words [c_WORDS];
  logic [WORD_WIDTH-1:0] w_raw;

  assign w_accept  = r_buf_valid && word_ready;
  assign w_at_last = (r_idx == c_LAST);

  // Refill either into an empty buffer or on the handshake of the last word,
  // so consecutive lines stream without a bubble.
  assign w_rd_en = !rst && (r_state == S_RUN) && (r_lines_left != '0) && !dma_empty &&
                   (!r_buf_valid || (word_ready && w_at_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_buf        <= '0;
      r_buf_valid  <= 1'b0;
      r_idx        <= '0;
      r_lines_left <= '0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (go) begin
            r_state      <= S_RUN;
            r_lines_left <= size;
            r_buf_valid  <= 1'b0;
            r_idx        <= '0;
            r_done       <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_rd_en) begin
            r_buf        <= dma_rd_data;
            r_buf_valid  <= 1'b1;
            r_idx        <= '0;
            r_lines_left <= r_lines_left - SIZE_WIDTH'(1);
          end else if (w_accept) begin
            if (w_at_last) begin
              r_buf_valid <= 1'b0;
              r_idx       <= '0;
            end else begin
              r_idx <= r_idx + c_IDX_W'(1);
            end
          end
          if ((r_lines_left == '0) && (!r_buf_valid || (w_accept && w_at_last))) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < c_WORDS; gi++) begin : g_words
      assign w_words[gi] = r_buf[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  assign w_raw = w_words[r_idx];

`ifdef CL_UNPACK_BYTE_SWAP_EN
  always_comb begin
    word_data = '0;
    for (int b = 0; b < WORD_WIDTH / 8; b++) begin
      word_data[b*8 +: 8] = w_raw[WORD_WIDTH - 8 - b*8 +: 8];
    end
  end
`else
  assign word_data = w_raw;
`endif

  assign dma_rd_en  = w_rd_en;
  assign word_valid = r_buf_valid;
  assign word_last  = r_buf_valid && w_at_last;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cl_word_unpacker.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_cl_word_unpacker                                                         |
// | Directed bench for cl_word_unpacker with a small model of the DMA FIFO.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_cl_word_unpacker;
  localparam int CLW = 512;
  localparam int WW  = 32;
  localparam int SW  = 43;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [SW-1:0] size;
  logic          dma_empty;
  logic [CLW-1:0] dma_rd_data;
  logic          dma_rd_en;
  logic          word_valid;
  logic [WW-1:0] word_data;
  logic          word_last;
  logic          word_ready;
  logic          done;

  always #5 clk = ~clk;

  cl_word_unpacker #(.CL_WIDTH(CLW), .WORD_WIDTH(WW), .SIZE_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .go(go), .size(size),
    .dma_empty(dma_empty), .dma_rd_data(dma_rd_data), .dma_rd_en(dma_rd_en),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
    .word_ready(word_ready), .done(done)
  );

  // First-word fall-through FIFO model
  logic [CLW-1:0] mem [8];
  int   wp = 0;
  int   rp = 0;
  int   pops = 0;
  logic force_empty = 1'b0;
  logic flush = 1'b0;

  assign dma_empty   = force_empty || (wp == rp);
  assign dma_rd_data = mem[rp % 8];

  always @(posedge clk) begin
    if (flush) rp <= wp;
    else if (dma_rd_en) begin
      rp   <= rp + 1;
      pops <= pops + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CLW-1:0] l);
    mem[wp % 8] = l;
    wp = wp + 1;
  endtask

  function automatic logic [CLW-1:0] mk(input logic [31:0] base);
    logic [CLW-1:0] l;
    for (int i = 0; i < CLW / WW; i++) l[i*WW +: WW] = base + 32'(i);
    return l;
  endfunction

  function automatic logic [31:0] xw(input logic [31:0] w);
`ifdef CL_UNPACK_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  typedef struct {
    bit          go;
    bit          ready;
    bit          exp_valid;
    logic [31:0] exp_data;
    bit          exp_last;
    bit          exp_rd_en;
    bit          exp_done;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] expw [48];
    logic [CLW-1:0] l;
    logic [31:0] held;
    int n, first, lastc, p0, vc;
    bit started, was_held;

    // Single-line stream: go at row 0, pop at row 1, words at rows 2..17, done at 18
    for (int k = 0; k < 19; k++) begin
      tbl[k] = '{go: (k == 0), ready: 1'b1,
                 exp_valid: (k >= 2 && k <= 17),
                 exp_data: (k >= 2 && k <= 17) ? xw(32'h100 + 32'(k - 2)) : 32'h0,
                 exp_last: (k == 17), exp_rd_en: (k == 1), exp_done: (k == 18)};
    end

    rst = 1'b1; go = 1'b0; size = '0; word_ready = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_valid", word_valid, 0);
    chk("rst_last", word_last, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", dma_rd_en, 0);
    chk("rst_data", word_data, 0);
    step();
    rst = 1'b0;
    push(mk(32'h100));
    step();
    @(negedge clk);
    chk("idle_rd_en", dma_rd_en, 0);
    step();

    size = SW'(1);
    for (int k = 0; k < 19; k++) begin
      go = tbl[k].go;
      word_ready = tbl[k].ready;
      @(negedge clk);
      chk($sformatf("t1_valid[%0d]", k), word_valid, tbl[k].exp_valid);
      if (tbl[k].exp_valid) chk($sformatf("t1_data[%0d]", k), word_data, tbl[k].exp_data);
      chk($sformatf("t1_last[%0d]", k), word_last, tbl[k].exp_last);
      chk($sformatf("t1_rd_en[%0d]", k), dma_rd_en, tbl[k].exp_rd_en);
      chk($sformatf("t1_done[%0d]", k), done, tbl[k].exp_done);
      step();
    end
    go = 1'b0;
    chk("t1_pops", pops, 1);

    // Back-to-back lines
    for (int ln = 0; ln < 3; ln++) begin
      l = mk(32'hA000_0000 + 32'(ln * 256));
      if (ln == 0) l[31:0] = 32'h1122_3344;
      push(l);
      for (int i = 0; i < 16; i++) expw[ln*16 + i] = xw(l[i*WW +: WW]);
    end
    p0 = pops; size = SW'(3); go = 1'b1; word_ready = 1'b1;
    @(negedge clk);
    chk("t2_done_held_on_go", done, 1);
    step();
    go = 1'b0;
    n = 0; first = -1; lastc = -1;
    for (int cyc = 1; cyc < 60; cyc++) begin
      @(negedge clk);
      if (dma_rd_en) chk("t2_pop_align", (word_last || !word_valid), 1);
      if (word_valid && n < 48) begin
        chk($sformatf("t2_data[%0d]", n), word_data, expw[n]);
        chk($sformatf("t2_last[%0d]", n), word_last, (n % 16 == 15));
        if (n == 0) first = cyc;
        lastc = cyc;
        n++;
      end
      step();
    end
    chk("t2_count", n, 48);
    chk("t2_first_cycle", first, 2);
    chk("t2_span", lastc - first, 47);
    chk("t2_pops", pops - p0, 3);
    chk("t2_done", done, 1);

    // Backpressure: ready alternates starting on the first valid cycle
    push(mk(32'h300));
    p0 = pops; size = SW'(1); go = 1'b1; word_ready = 1'b0;
    step();
    go = 1'b0;
    n = 0; vc = 0; started = 0; was_held = 0; lastc = -1; held = '0;
    for (int cyc = 0; cyc < 80 && n < 16; cyc++) begin
      if (word_valid) started = 1;
      word_ready = started && (vc % 2 == 0);
      @(negedge clk);
      if (word_valid) begin
        if (was_held) chk("t3_hold", word_data, held);
        if (word_ready) begin
          chk($sformatf("t3_data[%0d]", n), word_data, xw(32'h300 + 32'(n)));
          lastc = vc;
          n++;
        end
        was_held = !word_ready;
        held = word_data;
      end
      if (started) vc++;
      step();
    end
    chk("t3_count", n, 16);
    chk("t3_span", lastc + 1, 31);
    word_ready = 1'b1;
    @(negedge clk);
    chk("t3_done", done, 1);
    chk("t3_pops", pops - p0, 1);
    step();

    // Empty stall then release
    force_empty = 1'b1;
    push(mk(32'h400)); push(mk(32'h410));
    size = SW'(2); go = 1'b1;
    step();
    go = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("t4_stall_rd_en[%0d]", c), dma_rd_en, 0);
      chk($sformatf("t4_stall_valid[%0d]", c), word_valid, 0);
      step();
    end
    force_empty = 1'b0;
    @(negedge clk);
    chk("t4_resume_pop", dma_rd_en, 1);
    step();
    n = 0; first = -1;
    for (int cyc = 1; cyc < 60; cyc++) begin
      @(negedge clk);
      if (word_valid && n < 32) begin
        chk($sformatf("t4_data[%0d]", n), word_data, xw(32'h400 + 32'(n)));
        if (n == 0) first = cyc;
        n++;
      end
      step();
    end
    chk("t4_first_cycle", first, 1);
    chk("t4_count", n, 32);
    chk("t4_done", done, 1);

    // size = 0
    p0 = pops; size = '0; go = 1'b1;
    step();
    go = 1'b0;
    @(negedge clk);
    chk("t5_done_t1", done, 0);
    chk("t5_rd_en_t1", dma_rd_en, 0);
    step();
    @(negedge clk);
    chk("t5_done_t2", done, 1);
    chk("t5_pops", pops - p0, 0);
    step();

    // Reset in the middle of the first line
    push(mk(32'h500)); push(mk(32'h510));
    size = SW'(2); go = 1'b1; word_ready = 1'b1;
    step();
    go = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 20 && n == 0; cyc++) begin
      @(negedge clk);
      if (word_valid && word_data == xw(32'h505)) n = 1;
      step();
    end
    chk("t6_reached_word5", n, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rd_en_in_rst", dma_rd_en, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", word_valid, 0);
    chk("t6_done", done, 0);
    chk("t6_rd_en", dma_rd_en, 0);
    chk("t6_data", word_data, 0);
    chk("t6_last", word_last, 0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    push(mk(32'h600));
    size = SW'(1); go = 1'b1;
    step();
    go = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (word_valid && n < 16) begin
        chk($sformatf("t6_data[%0d]", n), word_data, xw(32'h600 + 32'(n)));
        n++;
      end
      step();
    end
    chk("t6_count", n, 16);
    chk("t6_done_after", done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cl_word_unpacker.md
# cl_word_unpacker

Read-side stage between the DMA read channel and the miner's 32-bit word datapath. It pops 512-bit cache lines from the DMA read FIFO and presents them as a stream of 32-bit words under a valid/ready handshake. It counts lines against a software-supplied size and asserts done once the last word of the last line has been consumed. Sustained throughput is one word per cycle, with no bubble at line boundaries.

## Interface
Parameters:
- CL_WIDTH, 512, cache-line width in bits; must be WORD_WIDTH × power of two
- WORD_WIDTH, 32, output word width
- SIZE_WIDTH, 43, width of the line-count input (clAddr width + 1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- go  in  1  single-cycle start pulse; samples size
- size  in  SIZE_WIDTH  number of cache lines to unpack
- dma_empty  in  1  DMA read FIFO empty (0 = rd_data valid, first-word fall-through)
- dma_rd_data  in  CL_WIDTH  head of DMA read FIFO
- dma_rd_en  out  1  pop DMA read FIFO this cycle
- word_valid  out  1  word_data valid
- word_data  out  WORD_WIDTH  current word
- word_last  out  1  current word is the final word of its cache line
- word_ready  in  1  consumer accepts word this cycle
- done  out  1  all lines unpacked and all words consumed; held until next go

## Operation
- WORDS = CL_WIDTH/WORD_WIDTH (16 by default); idx is a log2(WORDS)-bit word index; lines_left is a SIZE_WIDTH-bit count.
- State machine IDLE → RUN → DONE.
  - IDLE: go → lines_left = size, buf_valid = 0, idx = 0, state = RUN.
  - RUN: when lines_left == 0 and (!buf_valid, or last word accepted this cycle) → DONE.
  - DONE: done = 1; go → reload and enter RUN the next cycle (done drops the same cycle state leaves DONE).
- go while in RUN is ignored.
- size = 0: go → RUN → DONE the following cycle; dma_rd_en never asserted.
- dma_rd_en is combinational: state==RUN && lines_left!=0 && !dma_empty && (!buf_valid || (word_ready && idx==WORDS-1)).
- On dma_rd_en:
  - buffer ← dma_rd_data
  - buf_valid ← 1
  - idx ← 0
  - lines_left ← lines_left − 1
- Word accepted (word_valid && word_ready):
  - idx increments.
  - At idx==WORDS-1 without a refill, buf_valid ← 0 and idx ← 0.
- word_valid = buf_valid; word_data = buffer[idx*WORD_WIDTH +: WORD_WIDTH], so word 0 is bits [31:0] and is emitted first.
- word_last = buf_valid && idx==WORDS-1.
- word_data is held stable while word_valid && !word_ready.
- Reset at any point:
  - state IDLE, buf_valid 0, idx 0, lines_left 0.
  - Outputs word_valid 0, word_last 0, done 0, word_data 0.
  - dma_rd_en is 0 during and after reset until the next go.
  - No partial line survives reset.

## Timing
- go at cycle T → dma_rd_en earliest at T+1 (if !dma_empty) → word_valid at T+2.
- Refill on the last-word handshake gives back-to-back lines: word 15 of line n at cycle C, word 0 of line n+1 at C+1.
- dma_empty asserted mid-stream: word_valid drops after the final word of the current line; it resumes the cycle after dma_rd_en fires.
- word_ready low: no advance and no pop, independent of dma_empty.
- done rises the cycle after the final word handshake; for size = 0, done rises at T+2.

## Configuration
- CL_UNPACK_BYTE_SWAP_EN defined: word_data is byte-reversed within each word (byte 0 ↔ byte 3), presenting big-endian SHA-256 message words.
- Undefined: word_data is the raw slice.
- Control timing is identical in both cases.

## Test plan
- Stream: size=1, one line with word i = i+0x100, word_ready=1 → 16 consecutive words 0x100..0x10F; word_last only on 0x10F; done one cycle later.
- Back-to-back lines: size=3, FIFO never empty, word_ready=1 → 48 words in 48 consecutive cycles; dma_rd_en pulses exactly 3 times, each coinciding with word_last or the initial load.
- Backpressure: word_ready toggles 1,0,1,0… → each word is held while ready=0; 16 words delivered in order over 31 cycles; no extra dma_rd_en.
- Empty stall plus size 0: dma_empty=1 for 10 cycles after go with size=2 → no dma_rd_en and no word_valid until the FIFO fills. Separately, size=0 → done at T+2 with zero pops.
- Reset mid-line: assert rst after word 5 of line 1 → next cycle word_valid=0, done=0, dma_rd_en=0. A new go with size=1 restarts cleanly at word 0.
- Byte swap (macro defined): word 0 = 0x11223344 → word_data = 0x44332211.
